// File: rtl/pupil_pkg.sv
// Shared constants and types for the pupil-detection line path.
package pupil_pkg;

  localparam int unsigned MAX_RESOLUTION = 112;
  localparam int unsigned PIXEL_WIDTH    = 8;
  localparam int unsigned LINE_WIDTH     = MAX_RESOLUTION * PIXEL_WIDTH;
  localparam int unsigned COUNT_WIDTH    = $clog2(MAX_RESOLUTION);
  localparam int unsigned ROW_WIDTH      = 8;

  localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(MAX_RESOLUTION - 1);

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_CAPTURE = 2'd1,
    CAP_DRAIN   = 2'd2
  } capture_state_e;

  // Pixel/row counter step that wraps after the last slot of a line or frame.
  function automatic logic [COUNT_WIDTH-1:0] wrap_inc(input logic [COUNT_WIDTH-1:0] value);
    return (value == LAST_INDEX) ? '0 : value + COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// Packs accepted pixels into the working line buffer and flags the last pixel.
// Slot MAX_RESOLUTION-1 is never stored: the completed word merges the live
// pixel so the line can be handed over in the same cycle it completes.
module pixel_packer
  import pupil_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [PIXEL_WIDTH-1:0] pixel,
  output logic                   line_complete,
  output logic [LINE_WIDTH-1:0]  line_word_c
);

  localparam int unsigned BUFFER_WIDTH = LINE_WIDTH - PIXEL_WIDTH;

  logic [COUNT_WIDTH-1:0]  pix_cnt;
  logic [BUFFER_WIDTH-1:0] buffer;

  // Slot pointer: restarts on frame start, wraps at end of line.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      pix_cnt <= '0;
    end else if (enable) begin
      pix_cnt <= wrap_inc(pix_cnt);
    end
  end

  // Working buffer for slots 0..MAX_RESOLUTION-2.
  always_ff @(posedge clock) begin
    if (reset) begin
      buffer <= '0;
    end else if (enable && (pix_cnt != LAST_INDEX)) begin
      buffer[32'(pix_cnt) * PIXEL_WIDTH +: PIXEL_WIDTH] <= pixel;
    end
  end

  assign line_complete = enable && (pix_cnt == LAST_INDEX);
  assign line_word_c   = {pixel, buffer};

endmodule

// File: rtl/line_capture.sv
// Camera line capture: frames the pixel stream into lines and hands each line
// to the pupil detector over a valid/ack handshake. Slow consumers cause
// dropped lines (flagged by overrun), never camera stalls.
module line_capture
  import pupil_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cam_frame_start,
  input  logic                   cam_pixel_valid,
  input  logic [PIXEL_WIDTH-1:0] cam_pixel,
  input  logic                   line_ack,
  output logic [LINE_WIDTH-1:0]  line_data,
  output logic                   line_valid,
  output logic [ROW_WIDTH-1:0]   line_number,
  output logic                   frame_capture_start,
  output logic                   frame_done,
  output logic                   overrun
);

  capture_state_e          state;
  capture_state_e          next_state;
  logic [COUNT_WIDTH-1:0]  row_cnt;
  logic                    pixel_en;
  logic                    line_complete;
  logic [LINE_WIDTH-1:0]   line_word_c;
  logic                    last_row;
  logic                    load_line;
  logic                    drop_line;
  logic                    release_line;
  logic                    finish_frame;

  // A frame start in the same cycle discards the pixel.
  assign pixel_en = (state == CAP_CAPTURE) && cam_pixel_valid && !cam_frame_start;
  assign last_row = (row_cnt == LAST_INDEX);

  pixel_packer u_pixel_packer (
    .clock         (clock),
    .reset         (reset),
    .clear         (cam_frame_start),
    .enable        (pixel_en),
    .pixel         (cam_pixel),
    .line_complete (line_complete),
    .line_word_c   (line_word_c)
  );

  // Capture state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CAP_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: frame start restarts capture from any state.
  always_comb begin
    next_state = state;
    if (cam_frame_start) begin
      next_state = CAP_CAPTURE;
    end else begin
      case (state)
        CAP_IDLE:    next_state = CAP_IDLE;
        CAP_CAPTURE: if (line_complete && last_row) next_state = CAP_DRAIN;
        CAP_DRAIN:   if (!line_valid || line_ack) next_state = CAP_IDLE;
        default:     next_state = CAP_IDLE;
      endcase
    end
  end

  // Handshake decisions for this cycle; all suppressed by a frame start.
  always_comb begin
    load_line    = 1'b0;
    drop_line    = 1'b0;
    release_line = 1'b0;
    finish_frame = 1'b0;
    if (!cam_frame_start) begin
      load_line    = line_complete && (!line_valid || line_ack);
      drop_line    = line_complete && line_valid && !line_ack;
      release_line = line_valid && line_ack;
      finish_frame = (state == CAP_DRAIN) && (!line_valid || line_ack);
    end
  end

  // Row counter, output line register and status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_cnt             <= '0;
      line_data           <= '0;
      line_valid          <= 1'b0;
      line_number         <= '0;
      frame_capture_start <= 1'b0;
      frame_done          <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      frame_capture_start <= cam_frame_start;
      frame_done          <= finish_frame;
      if (cam_frame_start) begin
        row_cnt    <= '0;
        line_valid <= 1'b0;
        overrun    <= 1'b0;
      end else begin
        if (line_complete) begin
          row_cnt <= wrap_inc(row_cnt);
        end
        if (load_line) begin
          line_data   <= line_word_c;
          line_number <= ROW_WIDTH'(row_cnt);
          line_valid  <= 1'b1;
        end else if (release_line) begin
          line_valid <= 1'b0;
        end
        if (drop_line) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_capture.sv
// Bench for line_capture: random/directed camera frames against a line-level
// reference model, with a negedge monitor draining expected-status and
// expected-line queues.
module tb_line_capture;
  import pupil_pkg::*;

  localparam int N = int'(MAX_RESOLUTION);

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   cam_frame_start;
  logic                   cam_pixel_valid;
  logic [PIXEL_WIDTH-1:0] cam_pixel;
  logic                   line_ack;
  logic [LINE_WIDTH-1:0]  line_data;
  logic                   line_valid;
  logic [ROW_WIDTH-1:0]   line_number;
  logic                   frame_capture_start;
  logic                   frame_done;
  logic                   overrun;

  line_capture dut (
    .clock               (clock),
    .reset               (reset),
    .cam_frame_start     (cam_frame_start),
    .cam_pixel_valid     (cam_pixel_valid),
    .cam_pixel           (cam_pixel),
    .line_ack            (line_ack),
    .line_data           (line_data),
    .line_valid          (line_valid),
    .line_number         (line_number),
    .frame_capture_start (frame_capture_start),
    .frame_done          (frame_done),
    .overrun             (overrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic                  valid;
    logic [7:0]            number;
    logic                  ovr;
    logic                  done;
    logic                  fcs;
    logic [LINE_WIDTH-1:0] data;
  } status_t;

  typedef struct packed {
    logic [7:0]            number;
    logic [LINE_WIDTH-1:0] data;
  } line_t;

  status_t status_q[$];
  line_t   line_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int consumed    = 0;
  int done_pulses = 0;

  // Reference model: frame phase 0 idle, 1 capturing, 2 draining.
  int                    m_phase;
  int                    m_pix;
  int                    m_row;
  byte unsigned          m_cur [N];
  logic                  m_valid;
  logic                  m_ovr;
  logic                  m_done;
  logic                  m_fcs;
  logic [7:0]            m_num;
  logic [LINE_WIDTH-1:0] m_data;

  function automatic int first_diff(input logic [LINE_WIDTH-1:0] a, input logic [LINE_WIDTH-1:0] b);
    for (int k = 0; k < N; k++) begin
      if (a[k*8 +: 8] !== b[k*8 +: 8]) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic st, input logic pv,
                            input logic [7:0] px, input logic ack);
    logic was_valid;
    was_valid = m_valid;
    m_done = 1'b0;
    m_fcs  = 1'b0;
    if (rst) begin
      m_phase = 0; m_pix = 0; m_row = 0;
      m_valid = 1'b0; m_ovr = 1'b0; m_num = '0; m_data = '0;
      return;
    end
    if (was_valid && ack) line_q.push_back('{m_num, m_data});
    if (st) begin
      m_phase = 1; m_pix = 0; m_row = 0;
      m_valid = 1'b0; m_ovr = 1'b0; m_fcs = 1'b1;
      return;
    end
    if (was_valid && ack) m_valid = 1'b0;
    if (m_phase == 1 && pv) begin
      m_cur[m_pix] = px;
      if (m_pix == N - 1) begin
        m_pix = 0;
        if (!was_valid || ack) begin
          m_valid = 1'b1;
          m_num   = 8'(m_row);
          for (int k = 0; k < N; k++) m_data[k*8 +: 8] = m_cur[k];
        end else begin
          m_ovr = 1'b1;
        end
        if (m_row == N - 1) begin
          m_row   = 0;
          m_phase = 2;
        end else begin
          m_row++;
        end
      end else begin
        m_pix++;
      end
    end else if (m_phase == 2 && (!was_valid || ack)) begin
      m_phase = 0;
      m_done  = 1'b1;
    end
  endtask

  task automatic cycle(input logic rst, input logic st, input logic pv,
                       input logic [7:0] px, input logic ack);
    reset           = rst;
    cam_frame_start = st;
    cam_pixel_valid = pv;
    cam_pixel       = px;
    line_ack        = ack;
    model_step(rst, st, pv, px, ack);
    @(posedge clock);
    #1;
    status_q.push_back('{m_valid, m_num, m_ovr, m_done, m_fcs, m_data});
  endtask

  function automatic logic pick_ack(input int scen, input int r, input int k);
    case (scen)
      0: return 1'b1;
      1: begin
        if (r <= 1) return 1'b0;
        if (r == 2) return 1'(k == 0);
        if (r == 3) return 1'(k == N - 1);
        return 1'($urandom_range(0, 199) == 0);
      end
      2: return 1'($urandom_range(0, 149) == 0);
      3: return 1'(r != 50);
      4: return 1'(r != N - 1);
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_frame(input int scen, input int off, input bit send_start,
                           input bit gaps, input int abort_row, input int abort_pix);
    if (send_start) cycle(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0);
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) begin
        if (r == abort_row && k == abort_pix) begin
          cycle(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
          return;
        end
        if (gaps) begin
          while ($urandom_range(0, 7) == 0)
            cycle(1'b0, 1'b0, 1'b0, 8'($urandom), pick_ack(scen, r, k));
        end
        cycle(1'b0, 1'b0, 1'b1, 8'((r + k + off) % 256), pick_ack(scen, r, k));
      end
    end
  endtask

  task automatic check_count(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: compare DUT state after each edge and every consumed line.
  always @(negedge clock) begin
    status_t e;
    status_t a;
    line_t   l;
    if (status_q.size() != 0) begin
      e = status_q.pop_front();
      a = '{line_valid, line_number, overrun, frame_done, frame_capture_start, line_data};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL status @%0t: valid %b/%b number %0d/%0d overrun %b/%b frame_done %b/%b frame_capture_start %b/%b first_bad_pixel %0d (actual/expected)",
                 $time, a.valid, e.valid, a.number, e.number, a.ovr, e.ovr,
                 a.done, e.done, a.fcs, e.fcs, first_diff(a.data, e.data));
      end
    end
    if (line_valid === 1'b1 && line_ack === 1'b1) begin
      consumed++;
      vectors++;
      if (line_q.size() == 0) begin
        miscompares++;
        $display("FAIL line_take @%0t: line %0d consumed, none expected", $time, line_number);
      end else begin
        l = line_q.pop_front();
        if (l.number !== line_number || l.data !== line_data) begin
          miscompares++;
          $display("FAIL line_take @%0t: number %0d expected %0d, first bad pixel %0d",
                   $time, line_number, l.number, first_diff(line_data, l.data));
        end
      end
    end
    if (frame_done === 1'b1) done_pulses++;
  end

  initial begin
    int c0;
    int d0;
    reset = 1'b1; cam_frame_start = 1'b0; cam_pixel_valid = 1'b0;
    cam_pixel = '0; line_ack = 1'b0;

    // Reset, then pixels in IDLE must be ignored.
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'h33, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);

    // Full frame, ack tied high.
    c0 = consumed; d0 = done_pulses;
    run_frame(0, 0, 1'b1, 1'b0, -1, -1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_count("frame1_lines", consumed - c0, N);
    check_count("frame1_done", done_pulses - d0, 1);

    // Dropped line 1, then simultaneous ack/transfer on line 3, then sparse acks.
    d0 = done_pulses;
    run_frame(1, 8'h11, 1'b1, 1'b0, -1, -1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_count("frame2_done", done_pulses - d0, 1);

    // Abort at row 50 pixel 40, restart, then reset while draining a pending line.
    d0 = done_pulses;
    run_frame(3, 8'h40, 1'b1, 1'b0, 50, 40);
    run_frame(4, 8'h80, 1'b0, 1'b0, -1, -1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1);
    check_count("abort_reset_done", done_pulses - d0, 0);

    // Random pixel gaps and sparse acks.
    d0 = done_pulses;
    run_frame(2, 7, 1'b1, 1'b1, -1, -1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_count("frame4_done", done_pulses - d0, 1);

    @(negedge clock);
    #1;
    check_count("lines_left", line_q.size(), 0);
    check_count("status_left", status_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
